// File: rtl/pulse_period_meter_if.sv
// Control/result bundle for pulse_period_meter: start request with latched
// parameters going in, status and held measurement results coming out.
interface pulse_period_meter_if #(
    parameter int unsigned CNT_WIDTH = 32
);
    logic                 start;
    logic [7:0]           nper;
    logic [CNT_WIDTH-1:0] tout;
    logic                 busy;
    logic                 done;
    logic                 err;
    logic [CNT_WIDTH-1:0] period_o;
    logic [CNT_WIDTH-1:0] high_o;

    modport master (
        output start, nper, tout,
        input  busy, done, err, period_o, high_o
    );

    modport slave (
        input  start, nper, tout,
        output busy, done, err, period_o, high_o
    );
endinterface

// File: rtl/pulse_period_meter.sv
// Measures clk cycles spanning nper periods of an asynchronous square wave, with timeout.
// High-time (duty) measurement is built only when PPM_DUTY_MEASURE_EN is defined.
module pulse_period_meter #(
    parameter int unsigned CNT_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  pulse_i,
    pulse_period_meter_if.slave   bus
);
    localparam int unsigned CW = CNT_WIDTH;

    typedef enum logic [1:0] {StIdle, StWaitFirst, StMeasure, StDone} state_e;

    state_e          state_q, state_d;
    logic            sync1_q, sync2_q, dly_q;
    logic [7:0]      nper_q, nper_d;
    logic [7:0]      edge_q, edge_d;
    logic [CW-1:0]   tout_q, tout_d;
    logic [CW-1:0]   since_q, since_d;
    logic [CW-1:0]   cyc_q, cyc_d;
    logic [CW-1:0]   period_q, period_d;
    logic            err_q, err_d;

    logic            rise;
    logic            tmo;
    logic [CW-1:0]   since_inc, cyc_inc;
    logic [7:0]      edge_inc;

    assign rise      = sync2_q & ~dly_q;
    assign tmo       = (tout_q != '0) && (since_q == tout_q);
    assign since_inc = (since_q == '1) ? since_q : since_q + CW'(1);
    assign cyc_inc   = (cyc_q == '1) ? cyc_q : cyc_q + CW'(1);
    assign edge_inc  = edge_q + 8'd1;

`ifdef PPM_DUTY_MEASURE_EN
    logic [CW-1:0] high_q, high_d;
    logic [CW-1:0] high_res_q, high_res_d;
    logic [CW-1:0] high_inc;

    assign high_inc = (high_q == '1) ? high_q : high_q + CW'(1);
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            dly_q   <= 1'b0;
        end else begin
            sync1_q <= pulse_i;
            sync2_q <= sync1_q;
            dly_q   <= sync2_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            nper_q   <= '0;
            edge_q   <= '0;
            tout_q   <= '0;
            since_q  <= '0;
            cyc_q    <= '0;
            period_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            nper_q   <= nper_d;
            edge_q   <= edge_d;
            tout_q   <= tout_d;
            since_q  <= since_d;
            cyc_q    <= cyc_d;
            period_q <= period_d;
            err_q    <= err_d;
        end
    end

`ifdef PPM_DUTY_MEASURE_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            high_q     <= '0;
            high_res_q <= '0;
        end else begin
            high_q     <= high_d;
            high_res_q <= high_res_d;
        end
    end
`endif

    always_comb begin
        state_d  = state_q;
        nper_d   = nper_q;
        edge_d   = edge_q;
        tout_d   = tout_q;
        since_d  = since_q;
        cyc_d    = cyc_q;
        period_d = period_q;
        err_d    = err_q;
`ifdef PPM_DUTY_MEASURE_EN
        high_d     = high_q;
        high_res_d = high_res_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    nper_d  = (bus.nper == 8'd0) ? 8'd1 : bus.nper;
                    tout_d  = bus.tout;
                    since_d = '0;
                    state_d = StWaitFirst;
                end
            end
            StWaitFirst: begin
                if (rise) begin
                    since_d = '0;
                    cyc_d   = '0;
                    edge_d  = '0;
`ifdef PPM_DUTY_MEASURE_EN
                    high_d  = '0;
`endif
                    state_d = StMeasure;
                end else if (tmo) begin
                    err_d    = 1'b1;
                    period_d = '0;
`ifdef PPM_DUTY_MEASURE_EN
                    high_res_d = '0;
`endif
                    state_d  = StDone;
                end else begin
                    since_d = since_inc;
                end
            end
            StMeasure: begin
                cyc_d = cyc_inc;
`ifdef PPM_DUTY_MEASURE_EN
                if (sync2_q) high_d = high_inc;
`endif
                if (rise) begin
                    since_d = '0;
                    edge_d  = edge_inc;
                    // The closing edge cycle is included, so N periods of P give exactly N*P.
                    if (edge_inc == nper_q) begin
                        period_d = cyc_inc;
`ifdef PPM_DUTY_MEASURE_EN
                        high_res_d = high_inc;
`endif
                        err_d    = 1'b0;
                        state_d  = StDone;
                    end
                end else if (tmo) begin
                    err_d    = 1'b1;
                    period_d = '0;
`ifdef PPM_DUTY_MEASURE_EN
                    high_res_d = '0;
`endif
                    state_d  = StDone;
                end else begin
                    since_d = since_inc;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign bus.busy     = (state_q == StWaitFirst) || (state_q == StMeasure);
    assign bus.done     = (state_q == StDone);
    assign bus.err      = err_q;
    assign bus.period_o = period_q;
`ifdef PPM_DUTY_MEASURE_EN
    assign bus.high_o   = high_res_q;
`else
    assign bus.high_o   = '0;
`endif

endmodule

// File: tb/tb_pulse_period_meter.sv
// Directed bench for pulse_period_meter: period/duty results, nper=0, timeout timing,
// mid-measurement reset and ignored restart.
module tb_pulse_period_meter;
    localparam int unsigned CW = 32;
`ifdef PPM_DUTY_MEASURE_EN
    localparam bit Duty = 1'b1;
`else
    localparam bit Duty = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic pulse;
    bit   pulse_run = 1'b0;
    int   ph = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    pulse_period_meter_if #(.CNT_WIDTH(CW)) bif ();

    pulse_period_meter #(.CNT_WIDTH(CW)) dut (
        .clk     (clk),
        .reset   (reset),
        .pulse_i (pulse),
        .bus     (bif.slave)
    );

    always #5 clk = ~clk;

    // Square wave: period 100 clk cycles, 50 high.
    always @(posedge clk) ph <= (ph == 99) ? 0 : ph + 1;
    assign pulse = pulse_run && (ph < 50);

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    // Starts a measurement, optionally re-pulses start after restart_at cycles,
    // and returns cycles until done plus the number of done pulses seen.
    task automatic run_meas(input logic [7:0] n, input logic [CW-1:0] t, input int budget,
                            input int restart_at, output int cycles, output int dones);
        @(negedge clk);
        bif.start = 1'b1;
        bif.nper  = n;
        bif.tout  = t;
        @(negedge clk);
        bif.start = 1'b0;
        bif.nper  = 8'd77;
        bif.tout  = 5;
        cycles = 0;
        dones  = 0;
        while (cycles < budget && dones == 0) begin
            @(negedge clk);
            cycles++;
            if (restart_at != 0 && cycles == restart_at) begin
                check_eq("busy_at_restart", {63'd0, bif.busy}, 64'd1);
                bif.start = 1'b1;
            end else begin
                bif.start = 1'b0;
            end
            if (bif.done) dones++;
        end
        if (dones == 0) check_eq("done_within_budget", 64'd0, 64'd1);
        repeat (5) begin
            @(negedge clk);
            if (bif.done) dones++;
        end
    endtask

    initial begin
        int cyc, dn;
        bif.start = 1'b0;
        bif.nper  = 8'd0;
        bif.tout  = '0;

        repeat (3) @(negedge clk);
        check_eq("rst_busy",   {63'd0, bif.busy}, 64'd0);
        check_eq("rst_done",   {63'd0, bif.done}, 64'd0);
        check_eq("rst_err",    {63'd0, bif.err},  64'd0);
        check_eq("rst_period", 64'(bif.period_o), 64'd0);
        check_eq("rst_high",   64'(bif.high_o),   64'd0);
        reset = 1'b0;
        pulse_run = 1'b1;
        repeat (20) @(negedge clk);

        run_meas(8'd1, '0, 2000, 0, cyc, dn);
        check_eq("n1_dones",  64'(dn), 64'd1);
        check_eq("n1_period", 64'(bif.period_o), 64'd100);
        check_eq("n1_high",   64'(bif.high_o), Duty ? 64'd50 : 64'd0);
        check_eq("n1_err",    {63'd0, bif.err}, 64'd0);
        check_eq("n1_busy",   {63'd0, bif.busy}, 64'd0);

        run_meas(8'd4, '0, 2000, 0, cyc, dn);
        check_eq("n4_dones",  64'(dn), 64'd1);
        check_eq("n4_period", 64'(bif.period_o), 64'd400);
        check_eq("n4_high",   64'(bif.high_o), Duty ? 64'd200 : 64'd0);

        run_meas(8'd0, '0, 2000, 0, cyc, dn);
        check_eq("n0_period", 64'(bif.period_o), 64'd100);

        run_meas(8'd2, '0, 2000, 150, cyc, dn);
        check_eq("restart_dones",  64'(dn), 64'd1);
        check_eq("restart_period", 64'(bif.period_o), 64'd200);
        repeat (300) @(negedge clk);
        check_eq("restart_idle_busy", {63'd0, bif.busy}, 64'd0);
        check_eq("restart_held",      64'(bif.period_o), 64'd200);

        // Abort a nper=8 measurement after a few edges.
        @(negedge clk);
        bif.start = 1'b1;
        bif.nper  = 8'd8;
        bif.tout  = '0;
        @(negedge clk);
        bif.start = 1'b0;
        repeat (350) @(negedge clk);
        check_eq("pre_rst_busy", {63'd0, bif.busy}, 64'd1);
        reset = 1'b1;
        #1;
        check_eq("mid_rst_busy",   {63'd0, bif.busy}, 64'd0);
        check_eq("mid_rst_period", 64'(bif.period_o), 64'd0);
        check_eq("mid_rst_high",   64'(bif.high_o), 64'd0);
        check_eq("mid_rst_err",    {63'd0, bif.err}, 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        dn = 0;
        repeat (1000) begin
            @(negedge clk);
            if (bif.done) dn++;
            if (bif.busy) dn += 100;
        end
        check_eq("post_rst_quiet", 64'(dn), 64'd0);

        run_meas(8'd8, '0, 3000, 0, cyc, dn);
        check_eq("n8_dones",  64'(dn), 64'd1);
        check_eq("n8_period", 64'(bif.period_o), 64'd800);
        check_eq("n8_high",   64'(bif.high_o), Duty ? 64'd400 : 64'd0);

        // Timeout: input parked low, done one cycle after the since-edge count hits 1000.
        pulse_run = 1'b0;
        repeat (10) @(negedge clk);
        run_meas(8'd1, CW'(1000), 3000, 0, cyc, dn);
        check_eq("tmo_latency", 64'(cyc), 64'd1001);
        check_eq("tmo_dones",   64'(dn), 64'd1);
        check_eq("tmo_err",     {63'd0, bif.err}, 64'd1);
        check_eq("tmo_period",  64'(bif.period_o), 64'd0);
        check_eq("tmo_high",    64'(bif.high_o), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
